// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: accumulates systolic-array psum vectors over several K-tile passes
// into a wide row buffer, then drains the finished tile over a valid/ready stream.
// Optional build macro PSUM_ACCUM_SATURATE_EN: saturating accumulation, clamps set err.
// Without it, accumulation wraps modulo 2^ACC_WIDTH.
module psum_accum_buffer #(
    parameter int unsigned PSUM_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned ARRAY_WIDTH = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PASS_WIDTH  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(DEPTH+1)-1:0]             cfg_rows,
    input  logic [PASS_WIDTH-1:0]                  cfg_passes,
    input  logic                                   psum_valid,
    // Each element is a two's-complement psum.
    input  logic [ARRAY_WIDTH-1:0][PSUM_WIDTH-1:0] psum_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    // Each element is a two's-complement accumulator value.
    output logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0]  out_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int unsigned RowW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain
    } state_e;

    typedef logic [ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] acc_row_t;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [RowW-1:0]       rows_q, rows_d;
    logic [PASS_WIDTH-1:0] passes_q, passes_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    acc_row_t              row_buf_q [DEPTH];
    acc_row_t              acc_row;
    logic                  buf_we;
    logic                  sat_hit;

    logic                  cfg_ok;
    logic                  last_wr_row;
    logic                  last_pass;
    logic                  last_rd_row;

    assign cfg_ok = (cfg_rows != '0) && (cfg_rows <= RowW'(DEPTH)) && (cfg_passes != '0);
    assign last_wr_row = (RowW'(wr_ptr_q) == (rows_q - RowW'(1)));
    assign last_pass   = (pass_cnt_q == (passes_q - PASS_WIDTH'(1)));
    assign last_rd_row = (RowW'(rd_ptr_q) == (rows_q - RowW'(1)));

    // Per-element read-modify-write sum for the row at wr_ptr; first pass ignores old contents.
    always_comb begin : acc_calc
        logic signed [PSUM_WIDTH-1:0] p;
        logic signed [ACC_WIDTH-1:0]  base;
        logic signed [ACC_WIDTH-1:0]  ext;
        logic signed [ACC_WIDTH-1:0]  sum;
        sat_hit = 1'b0;
        acc_row = '0;
        p       = '0;
        base    = '0;
        ext     = '0;
        sum     = '0;
        for (int j = 0; j < ARRAY_WIDTH; j++) begin
            p    = psum_in[j];
            ext  = ACC_WIDTH'(p);
            base = (pass_cnt_q == '0) ? '0 : row_buf_q[wr_ptr_q][j];
            sum  = base + ext;
`ifdef PSUM_ACCUM_SATURATE_EN
            // Overflow only when both operands share a sign the result does not.
            if ((base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1])) begin
                sat_hit = 1'b1;
                sum = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
`endif
            acc_row[j] = sum;
        end
    end

    // Next-state and control decode for the IDLE/ACCUM/DRAIN controller.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
        rows_d     = rows_q;
        passes_d   = passes_q;
        err_d      = err_q;
        done_d     = 1'b0;
        buf_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        rows_d     = cfg_rows;
                        passes_d   = cfg_passes;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        pass_cnt_d = '0;
                        state_d    = StAccum;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StAccum: begin
                if (psum_valid) begin
                    buf_we = 1'b1;
                    if (sat_hit) begin
                        err_d = 1'b1;
                    end
                    if (last_wr_row) begin
                        wr_ptr_d   = '0;
                        pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                        if (last_pass) begin
                            rd_ptr_d = '0;
                            state_d  = StDrain;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                    end
                end
            end
            StDrain: begin
                // Array output arriving while draining has nowhere to go.
                if (psum_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    if (last_rd_row) begin
                        rd_ptr_d = '0;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PtrW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            rows_q     <= '0;
            passes_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            rows_q     <= rows_d;
            passes_q   <= passes_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // Row buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf_q[wr_ptr_q] <= acc_row;
        end
    end

    assign out_valid = (state_q == StDrain);
    assign out_data  = row_buf_q[rd_ptr_q];
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule
